mem_responder: RTL and testbench

- Word-addressed data RAM that answers the CPU's load/store requests: the responder end of the CPU memory interface.
- Accepts one request at a time over a valid/ready request channel and returns read data or a write acknowledgement over a valid/ready response channel.
- Has a configurable wait-state count so CPU stall logic can be exercised.
- Sits between the CPU's lw/sw datapath and the 4K-word data store.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_array.sv | 24 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the CPU data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 4096;
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// CPU data-memory responder: one outstanding request, programmable wait states.
// Optional access counters (rd_count/wr_count) are built when MEM_ACCESS_CNT_EN is defined.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_we
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  state_t                  state_reg;
  logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
  logic [DATA_W-1:0]       rdata_reg;
  logic                    err_reg;
  logic                    we_reg;

  logic                    accept;
  logic                    in_range;
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_W-1:0]       mem_rdata;

  // Range check uses the full address so high bits can never alias into the array.
  assign in_range = (req_addr < ADDR_W'(DEPTH));
  assign mem_idx  = req_addr[IDX_W-1:0];
  assign accept   = req_valid && req_ready;
  assign mem_we   = accept && req_we && in_range;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_idx),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      we_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rdata_reg <= (!req_we && in_range) ? mem_rdata : '0;
            err_reg   <= !in_range;
            we_reg    <= req_we;
            if (WAIT_STATES == 0) begin
              state_reg <= RESP;
            end else begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign rsp_we    = we_reg;

`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] rd_count_reg;
  logic [31:0] wr_count_reg;

  // Only in-range accesses count; the adders wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else if (accept && in_range) begin
      if (req_we) begin
        wr_count_reg <= wr_count_reg + 32'd1;
      end else begin
        rd_count_reg <= rd_count_reg + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_STATES = 1, 0 and 3.
module tb_mem_responder;

  logic        clk;
  logic [2:0]  reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_we;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [2:0]  rsp_err;
  logic [2:0]  rsp_we;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];
`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] rd_count  [3];
  logic [31:0] wr_count  [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      mem_responder #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH       (4096),
        .WAIT_STATES ((gi == 0) ? 1 : (gi == 1) ? 0 : 3)
      ) u_dut (
        .clk       (clk),
        .reset     (reset[gi]),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_we    (req_we[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_ready (rsp_ready[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi]),
        .rsp_we    (rsp_we[gi])
`ifdef MEM_ACCESS_CNT_EN
        ,
        .rd_count  (rd_count[gi]),
        .wr_count  (wr_count[gi])
`endif
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the acceptance edge.
  task automatic send(input int idx, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    req_valid[idx] = 1'b1;
    while (!req_ready[idx] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic finish_rsp(input int idx, input string tag);
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready[idx] = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, rsp_valid[idx]}, 32'd0);
    check({tag, "_req_ready"},  {31'd0, req_ready[idx]}, 32'd1);
  endtask

  task automatic xact(input int idx, input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input bit hold);
    int lat;
    send(idx, we, addr, wdata);
    lat = 1;
    while (!rsp_valid[idx] && lat < 40) begin
      tick();
      lat++;
    end
    $display("xact %s: dut=%0d we=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d",
             tag, idx, we, addr, rsp_rdata[idx], rsp_err[idx], lat);
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_rdata"}, rsp_rdata[idx], exp_rdata);
    check({tag, "_err"},   {31'd0, rsp_err[idx]}, {31'd0, exp_err});
    check({tag, "_we"},    {31'd0, rsp_we[idx]},  {31'd0, we});
    if (!hold) finish_rsp(idx, tag);
  endtask

  initial begin
    int t1;
    int t2;
    bit seen;
    reset     = 3'b111;
    req_valid = '0;
    req_we    = '0;
    rsp_ready = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", {31'd0, req_ready[i]}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      check("rst_rsp_err",   {31'd0, rsp_err[i]}, 32'd0);
      check("rst_rsp_we",    {31'd0, rsp_we[i]},  32'd0);
    end
    reset = 3'b000;
    tick();

    // WAIT_STATES=1: write then read back, 2-cycle latency each
    xact(0, "wr5", 1'b1, 32'h005, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b0);
    xact(0, "rd5", 1'b0, 32'h005, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);

    // Backpressure: response held for 5 cycles
    xact(0, "bp", 1'b0, 32'h005, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid",     {31'd0, rsp_valid[0]}, 32'd1);
      check("bp_rdata",     rsp_rdata[0], 32'hDEADBEEF);
      check("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    finish_rsp(0, "bp");

    // Out of range: no write, no aliasing onto index 0
    xact(0, "wr0",    1'b1, 32'h000, 32'h11111111, 32'h0, 1'b0, 2, 1'b0);
    xact(0, "wr_oor", 1'b1, 32'h1000, 32'h00001234, 32'h0, 1'b1, 2, 1'b0);
    xact(0, "rd0",    1'b0, 32'h000, 32'h0, 32'h11111111, 1'b0, 2, 1'b0);
    xact(0, "rd_oor", 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 2, 1'b0);
    xact(0, "wr_top", 1'b1, 32'hFFF, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b0);
    xact(0, "rd_top", 1'b0, 32'hFFF, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0);
    xact(0, "rd_max", 1'b0, 32'hFFFF_F000, 32'h0, 32'h0, 1'b1, 2, 1'b0);

`ifdef MEM_ACCESS_CNT_EN
    check("rd_count", rd_count[0], 32'd4);
    check("wr_count", wr_count[0], 32'd3);
`endif

    // WAIT_STATES=0: back-to-back reads with rsp_ready held high
    xact(1, "z_wr1", 1'b1, 32'h001, 32'h00000101, 32'h0, 1'b0, 1, 1'b0);
    xact(1, "z_wr2", 1'b1, 32'h002, 32'h00000202, 32'h0, 1'b0, 1, 1'b0);
    rsp_ready[1]   = 1'b1;
    req_we[1]      = 1'b0;
    req_addr[1]    = 32'h001;
    req_valid[1]   = 1'b1;
    tick();
    t1 = cyc;
    check("b2b_valid1", {31'd0, rsp_valid[1]}, 32'd1);
    check("b2b_rdata1", rsp_rdata[1], 32'h00000101);
    req_addr[1] = 32'h002;
    tick();
    check("b2b_gap_valid", {31'd0, rsp_valid[1]}, 32'd0);
    check("b2b_gap_ready", {31'd0, req_ready[1]}, 32'd1);
    tick();
    t2 = cyc;
    req_valid[1] = 1'b0;
    $display("xact b2b: dut=1 accept1=%0d accept2=%0d rdata2=0x%08h", t1, t2, rsp_rdata[1]);
    check("b2b_spacing", t2 - t1, 32'd2);
    check("b2b_valid2",  {31'd0, rsp_valid[1]}, 32'd1);
    check("b2b_rdata2",  rsp_rdata[1], 32'h00000202);
    tick();
    rsp_ready[1] = 1'b0;
    check("b2b_idle", {31'd0, req_ready[1]}, 32'd1);

    // WAIT_STATES=3: reset during WAIT drops the response but keeps the write
    send(2, 1'b1, 32'h010, 32'hA5A5A5A5);
    tick();
    check("rw_in_wait", {31'd0, rsp_valid[2]}, 32'd0);
    reset[2] = 1'b1;
    tick();
    reset[2] = 1'b0;
    seen = 1'b0;
    check("rw_req_ready", {31'd0, req_ready[2]}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid[2]) seen = 1'b1;
      tick();
    end
    $display("xact rst_wait: dut=2 rsp_valid_seen=%0d", seen);
    check("rw_no_rsp", {31'd0, seen}, 32'd0);
    xact(2, "rw_rd", 1'b0, 32'h010, 32'h0, 32'hA5A5A5A5, 1'b0, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
